// File: rtl/rr_grant_sched_pkg.sv
// Shared types and defaults for the round-robin grant scheduler.
// State encodings: StIdle = 1'b0, StGrant = 1'b1.
package rr_grant_sched_pkg;

  localparam int unsigned NDefault       = 8;
  localparam int unsigned HoldMaxDefault = 16;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  // Hold counter must represent HOLD_MAX itself, hence the extra bit.
  function automatic int unsigned hold_width(int unsigned hold_max);
    return $clog2(hold_max) + 1;
  endfunction

endpackage

// File: rtl/rr_grant_sched_if.sv
// Request/grant bundle between requesters (master) and the scheduler (slave).
interface rr_grant_sched_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 3
);
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic          switch;

  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  grant_idx,
    input  switch
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output grant_idx,
    output switch
  );
endinterface

// File: rtl/rr_grant_sched_pick.sv
// Combinational rotating-priority pick: lowest requester at or above ptr_i, else wrap to
// the lowest below it. Bits set in excl_i are never picked.
module rr_grant_sched_pick #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic [N-1:0]  excl_i,
  output logic [N-1:0]  pick_o,
  output logic [IW-1:0] pick_idx_o,
  output logic          pick_any_o
);

  localparam logic [2*N-1:0] One = {{(2*N-1){1'b0}}, 1'b1};

  logic [N-1:0]   req_m;
  logic [N-1:0]   ge_mask;
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] low;

  // Lower half holds only requests at/above ptr; the upper half is the wrap-around copy,
  // so isolating the lowest set bit of the doubled vector yields the rotated pick.
  always_comb begin
    req_m = req_i & ~excl_i;
    for (int i = 0; i < int'(N); i++) begin
      ge_mask[i] = (i >= int'(ptr_i));
    end
    dbl    = {req_m, req_m & ge_mask};
    low    = dbl & (~dbl + One);
    pick_o = low[N-1:0] | low[2*N-1:N];
  end

  always_comb begin
    pick_idx_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (pick_o[i]) pick_idx_o = pick_idx_o | IW'(i);
    end
    pick_any_o = |req_m;
  end

endmodule

// File: rtl/rr_grant_sched.sv
// Registered round-robin scheduler with grant locking and encoded grant index.
// Optional hold limit enabled by defining RR_GRANT_HOLD_LIMIT_EN.
module rr_grant_sched
  import rr_grant_sched_pkg::*;
#(
  parameter int unsigned N        = NDefault,
  parameter int unsigned IW       = $clog2(N)
`ifdef RR_GRANT_HOLD_LIMIT_EN
  ,
  parameter int unsigned HOLD_MAX = HoldMaxDefault,
  parameter int unsigned HW       = hold_width(HOLD_MAX)
`endif
) (
  input logic             clk,
  input logic             rst,
  rr_grant_sched_if.slave bus
);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          switch_q, switch_d;

  logic [N-1:0]  excl;
  logic [N-1:0]  pick;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          holder_req;
  logic          force_off;
  logic          take;

`ifdef RR_GRANT_HOLD_LIMIT_EN
  logic [HW-1:0] hold_q, hold_d;
`endif

  // In GRANT the holder is masked out, so pick_any means "someone else is waiting".
  assign excl = (state_q == StGrant) ? grant_q : '0;

  rr_grant_sched_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i      (bus.req),
    .ptr_i      (ptr_q),
    .excl_i     (excl),
    .pick_o     (pick),
    .pick_idx_o (pick_idx),
    .pick_any_o (pick_any)
  );

  assign holder_req = bus.req[idx_q];

`ifdef RR_GRANT_HOLD_LIMIT_EN
  assign force_off = (hold_q == HW'(HOLD_MAX)) && pick_any;
`else
  assign force_off = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    grant_d  = grant_q;
    switch_d = 1'b0;
    take     = 1'b0;
`ifdef RR_GRANT_HOLD_LIMIT_EN
    hold_d   = hold_q;
`endif

    unique case (state_q)
      StIdle: begin
        take = pick_any;
      end
      StGrant: begin
        if (holder_req && !force_off) begin
`ifdef RR_GRANT_HOLD_LIMIT_EN
          if (hold_q != HW'(HOLD_MAX)) hold_d = hold_q + 1'b1;
`endif
        end else if (pick_any) begin
          take = 1'b1;
        end else begin
          state_d = StIdle;
          grant_d = '0;
          idx_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (take) begin
      state_d  = StGrant;
      grant_d  = pick;
      idx_d    = pick_idx;
      ptr_d    = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
      switch_d = 1'b1;
`ifdef RR_GRANT_HOLD_LIMIT_EN
      hold_d   = HW'(1);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      idx_q    <= '0;
      grant_q  <= '0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      grant_q  <= grant_d;
      switch_q <= switch_d;
    end
  end

`ifdef RR_GRANT_HOLD_LIMIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`endif

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.switch      = switch_q;

endmodule
